// File: rtl/ifft8_pkg.sv
// Shared types and constants for the sequential 8-point inverse FFT.
// Holds the FSM state enum, Q1.14 twiddle tables (conjugate direction),
// the 3-bit bit-reversal helper and the 12-step butterfly schedule.
package ifft8_pkg;

    localparam int unsigned DW    = 16;  // sample width (re/im)
    localparam int unsigned TW    = 16;  // twiddle width
    localparam int unsigned TFRAC = 14;  // twiddle fractional bits
    localparam int unsigned NPT   = 8;   // transform size
    localparam int unsigned NSTEP = 12;  // 3 stages x 4 butterflies

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    // W8^-k = cos(2*pi*k/8) + j*sin(2*pi*k/8), k = 0..3
    localparam logic signed [TW-1:0] COS_K [4] = '{TW'(16384), TW'(11585), TW'(0), -TW'(11585)};
    localparam logic signed [TW-1:0] SIN_K [4] = '{TW'(0), TW'(11585), TW'(16384), TW'(11585)};

    // One butterfly: RAM indices of the pair and the twiddle index
    typedef struct packed {
        logic [2:0] ia;
        logic [2:0] ib;
        logic [1:0] k;
    } step_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction

    // Decimation-in-time schedule: spans 1, 2, 4
    function automatic step_t step_lut(input logic [3:0] s);
        case (s)
            4'd0:    return step_t'{3'd0, 3'd1, 2'd0};
            4'd1:    return step_t'{3'd2, 3'd3, 2'd0};
            4'd2:    return step_t'{3'd4, 3'd5, 2'd0};
            4'd3:    return step_t'{3'd6, 3'd7, 2'd0};
            4'd4:    return step_t'{3'd0, 3'd2, 2'd0};
            4'd5:    return step_t'{3'd1, 3'd3, 2'd2};
            4'd6:    return step_t'{3'd4, 3'd6, 2'd0};
            4'd7:    return step_t'{3'd5, 3'd7, 2'd2};
            4'd8:    return step_t'{3'd0, 3'd4, 2'd0};
            4'd9:    return step_t'{3'd1, 3'd5, 2'd1};
            4'd10:   return step_t'{3'd2, 3'd6, 2'd2};
            4'd11:   return step_t'{3'd3, 3'd7, 2'd3};
            default: return step_t'{3'd0, 3'd1, 2'd0};
        endcase
    endfunction

endpackage

// File: rtl/ifft8pt_seq_if.sv
// Stream bundle for ifft8pt_seq: bin input (s_*) and sample output (m_*).
// slave  : the transform block's view.
// master : the surrounding logic / testbench view.
interface ifft8pt_seq_if;
    import ifft8_pkg::*;

    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_re;
    logic signed [DW-1:0] s_im;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [DW-1:0] m_re;
    logic signed [DW-1:0] m_im;
    logic                 m_last;

    modport master (
        output s_valid, s_re, s_im, m_ready,
        input  s_ready, m_valid, m_re, m_im, m_last
    );

    modport slave (
        input  s_valid, s_re, s_im, m_ready,
        output s_ready, m_valid, m_re, m_im, m_last
    );

endinterface

// File: rtl/ifft8_bfly.sv
// Combinational radix-2 butterfly: t = W*b, a' = sat((a+t)/2), b' = sat((a-t)/2).
// Ports: a_*, b_* input pair; w_* Q1.14 twiddle; x_*_c / y_*_c results for a / b.
// IFFT_ROUND_EN selects round-half-up on both shifts; otherwise floor truncation.
module ifft8_bfly
    import ifft8_pkg::*;
(
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    output logic signed [DW-1:0] x_re_c,
    output logic signed [DW-1:0] x_im_c,
    output logic signed [DW-1:0] y_re_c,
    output logic signed [DW-1:0] y_im_c
);

    localparam int unsigned PW = DW + TW;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned AW = DW + 2;
    localparam logic signed [AW-1:0] CLIP = AW'((1 << (DW - 1)) - 1);

    // Drop the twiddle fraction; |t| stays below 2^(DW) so AW bits hold it
    function automatic logic signed [AW-1:0] scale_tw(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] r;
`ifdef IFFT_ROUND_EN
        r = v + SW'(1 << (TFRAC - 1));
`else
        r = v;
`endif
        return AW'(r >>> TFRAC);
    endfunction

    // Per-stage 1/2 scaling
    function automatic logic signed [AW-1:0] half(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] r;
`ifdef IFFT_ROUND_EN
        r = v + AW'(1);
`else
        r = v;
`endif
        return r >>> 1;
    endfunction

    // Symmetric clip: -2^(DW-1) is never produced
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [AW-1:0] v);
        if (v > CLIP)  return DW'(CLIP);
        if (v < -CLIP) return DW'(-CLIP);
        return DW'(v);
    endfunction

    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [AW-1:0] t_re, t_im;

    always_comb begin
        p_rr   = PW'(b_re) * PW'(w_re);
        p_ii   = PW'(b_im) * PW'(w_im);
        p_ri   = PW'(b_re) * PW'(w_im);
        p_ir   = PW'(b_im) * PW'(w_re);
        t_re   = scale_tw(SW'(p_rr) - SW'(p_ii));
        t_im   = scale_tw(SW'(p_ri) + SW'(p_ir));
        x_re_c = sat_dw(half(AW'(a_re) + t_re));
        x_im_c = sat_dw(half(AW'(a_im) + t_im));
        y_re_c = sat_dw(half(AW'(a_re) - t_re));
        y_im_c = sat_dw(half(AW'(a_im) - t_im));
    end

endmodule

// File: rtl/ifft8pt_seq.sv
// Sequential 8-point complex inverse FFT, one butterfly per clock.
// Ports: clk, rst_n (synchronous, active low), bus (ifft8pt_seq_if.slave:
//   s_valid/s_ready/s_re/s_im bins in, m_valid/m_ready/m_re/m_im/m_last
//   samples out in natural order), busy (high in COMPUTE or UNLOAD).
// Build option: IFFT_ROUND_EN enables round-half-up in the butterfly.
module ifft8pt_seq
    import ifft8_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    ifft8pt_seq_if.slave       bus,
    output logic               busy
);

    state_t               state;
    logic [2:0]           idx;
    logic [2:0]           n;
    logic [3:0]           step;
    logic signed [DW-1:0] ram_re [NPT];
    logic signed [DW-1:0] ram_im [NPT];

    step_t                st;
    logic signed [DW-1:0] x_re, x_im, y_re, y_im;

    assign st = step_lut(step);

    ifft8_bfly u_bfly (
        .a_re   (ram_re[st.ia]),
        .a_im   (ram_im[st.ia]),
        .b_re   (ram_re[st.ib]),
        .b_im   (ram_im[st.ib]),
        .w_re   (COS_K[st.k]),
        .w_im   (SIN_K[st.k]),
        .x_re_c (x_re),
        .x_im_c (x_im),
        .y_re_c (y_re),
        .y_im_c (y_im)
    );

    // FSM, counters, RAM and registered stream outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= LOAD;
            idx         <= 3'd0;
            n           <= 3'd0;
            step        <= 4'd0;
            bus.s_ready <= 1'b1;
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
            bus.m_re    <= '0;
            bus.m_im    <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.s_valid && bus.s_ready) begin
                        ram_re[bitrev3(idx)] <= bus.s_re;
                        ram_im[bitrev3(idx)] <= bus.s_im;
                        idx                  <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state       <= COMPUTE;
                            step        <= 4'd0;
                            bus.s_ready <= 1'b0;
                            busy        <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    // Read and write-back of the pair share this cycle
                    ram_re[st.ia] <= x_re;
                    ram_im[st.ia] <= x_im;
                    ram_re[st.ib] <= y_re;
                    ram_im[st.ib] <= y_im;
                    step          <= step + 4'd1;
                    if (step == 4'(NSTEP - 1)) begin
                        state <= UNLOAD;
                        n     <= 3'd0;
                    end
                end
                UNLOAD: begin
                    if (!bus.m_valid) begin
                        // First cycle: RAM now holds the final stage results
                        bus.m_valid <= 1'b1;
                        bus.m_re    <= ram_re[n];
                        bus.m_im    <= ram_im[n];
                        bus.m_last  <= 1'b0;
                    end else if (bus.m_ready) begin
                        if (n == 3'd7) begin
                            state       <= LOAD;
                            idx         <= 3'd0;
                            bus.m_valid <= 1'b0;
                            bus.m_last  <= 1'b0;
                            bus.s_ready <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            n          <= n + 3'd1;
                            bus.m_re   <= ram_re[n + 3'd1];
                            bus.m_im   <= ram_im[n + 3'd1];
                            bus.m_last <= (n == 3'd6);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_ifft8pt_seq.sv
// Self-checking bench for ifft8pt_seq: table of known transforms, a fixed-point
// reference model feeding a scoreboard, backpressure, saturation and reset abort.
module tb_ifft8pt_seq;
    import ifft8_pkg::*;

    typedef longint larr_t [8];

    typedef struct packed {
        logic [7:0][15:0] in_re;
        logic [7:0][15:0] in_im;
        logic [7:0][15:0] ex_re;
        logic [7:0][15:0] ex_im;
        logic [3:0]       tol;
    } vec_t;

    typedef struct {
        int m_re;
        int m_im;
        int t_re;
        int t_im;
        int tol;
        bit has_tab;
    } exp_t;

    logic   clk, rst_n, busy;
    int     total, bad;
    exp_t   sbq [$];
    vec_t   vt [3];

    ifft8pt_seq_if bus ();

    ifft8pt_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic longint twc(input int k);
        case (k)
            0: return 16384;
            1: return 11585;
            2: return 0;
            default: return -11585;
        endcase
    endfunction

    function automatic longint tws(input int k);
        case (k)
            0: return 0;
            2: return 16384;
            default: return 11585;
        endcase
    endfunction

    function automatic longint shr(input longint v, input int sh);
        longint r;
        r = v;
`ifdef IFFT_ROUND_EN
        r = r + (longint'(1) << (sh - 1));
`endif
        return r >>> sh;
    endfunction

    function automatic longint sat(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32767) return -32767;
        return v;
    endfunction

    function automatic void model(input larr_t ir, input larr_t ii,
                                  output larr_t orr, output larr_t oi);
        larr_t  xr, xi;
        int     h, a, b, k, br;
        longint tr, ti, ar, ai;
        for (int i = 0; i < 8; i++) begin
            br = ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
            xr[br] = ir[i];
            xi[br] = ii[i];
        end
        for (int s = 0; s < 3; s++) begin
            h = 1 << s;
            for (int g = 0; g < 8; g += 2 * h) begin
                for (int p = 0; p < h; p++) begin
                    a  = g + p;
                    b  = a + h;
                    k  = p * (4 >> s);
                    tr = shr(xr[b] * twc(k) - xi[b] * tws(k), 14);
                    ti = shr(xr[b] * tws(k) + xi[b] * twc(k), 14);
                    ar = xr[a];
                    ai = xi[a];
                    xr[a] = sat(shr(ar + tr, 1));
                    xi[a] = sat(shr(ai + ti, 1));
                    xr[b] = sat(shr(ar - tr, 1));
                    xi[b] = sat(shr(ai - ti, 1));
                end
            end
        end
        orr = xr;
        oi  = xi;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input longint act, input longint req, input longint tol);
        total++;
        if (act > req + tol || act < req - tol) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (tol %0d) at %0t", nm, act, req, tol, $time);
        end
    endtask

    task automatic push_exp(input larr_t ir, input larr_t ii, input bit has_tab,
                            input larr_t tr, input larr_t ti, input int tol);
        larr_t mr, mi;
        exp_t  e;
        model(ir, ii, mr, mi);
        for (int i = 0; i < 8; i++) begin
            e.m_re    = int'(mr[i]);
            e.m_im    = int'(mi[i]);
            e.t_re    = int'(tr[i]);
            e.t_im    = int'(ti[i]);
            e.tol     = tol;
            e.has_tab = has_tab;
            sbq.push_back(e);
        end
    endtask

    // Drives 8 bins; returns at the negedge after the edge that accepts bin 7
    task automatic send_frame(input larr_t ir, input larr_t ii);
        int g;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_re    = 16'(ir[i]);
            bus.s_im    = 16'(ii[i]);
            g = 0;
            while (!bus.s_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (g >= 50) chk("s_ready_timeout", 0, 1, 0);
            @(posedge clk);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_re    = '0;
        bus.s_im    = '0;
    endtask

    // Counts cycles to m_valid; optionally offers junk bins during COMPUTE
    task automatic wait_out(input bit junk);
        int cyc;
        cyc = 0;
        chk("busy_compute", longint'(busy), 1, 0);
        chk("s_ready_compute", longint'(bus.s_ready), 0, 0);
        while (!bus.m_valid && cyc < 100) begin
            if (junk) begin
                bus.s_valid = 1'b1;
                bus.s_re    = 16'($urandom);
                bus.s_im    = 16'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        bus.s_valid = 1'b0;
        chk("latency", cyc, 13, 0);
    endtask

    task automatic recv_frame(input int stall_n, input int stall_len);
        int   g;
        logic signed [15:0] hr, hi;
        exp_t e;
        for (int n = 0; n < 8; n++) begin
            g = 0;
            while (!bus.m_valid && g < 20) begin
                @(negedge clk);
                g++;
            end
            chk("m_valid", longint'(bus.m_valid), 1, 0);
            if (n == stall_n) begin
                for (int c = 0; c < stall_len; c++) begin
                    hr = bus.m_re;
                    hi = bus.m_im;
                    @(negedge clk);
                    chk("hold_re", longint'(bus.m_re), longint'(hr), 0);
                    chk("hold_im", longint'(bus.m_im), longint'(hi), 0);
                    chk("hold_valid", longint'(bus.m_valid), 1, 0);
                    chk("hold_s_ready", longint'(bus.s_ready), 0, 0);
                end
            end
            if (sbq.size() == 0) begin
                chk("sb_empty", 1, 0, 0);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("y%0d_re_model", n), longint'(bus.m_re), e.m_re, 0);
                chk($sformatf("y%0d_im_model", n), longint'(bus.m_im), e.m_im, 0);
                if (e.has_tab) begin
                    chk($sformatf("y%0d_re_table", n), longint'(bus.m_re), e.t_re, e.tol);
                    chk($sformatf("y%0d_im_table", n), longint'(bus.m_im), e.t_im, e.tol);
                end
            end
            chk($sformatf("m_last_y%0d", n), longint'(bus.m_last), (n == 7) ? 1 : 0, 0);
            chk("clip_re", (bus.m_re == -16'sd32768) ? 1 : 0, 0, 0);
            chk("clip_im", (bus.m_im == -16'sd32768) ? 1 : 0, 0, 0);
            chk("s_ready_unload", longint'(bus.s_ready), 0, 0);
            bus.m_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.m_ready = 1'b0;
        end
        chk("s_ready_after", longint'(bus.s_ready), 1, 0);
        chk("m_valid_after", longint'(bus.m_valid), 0, 0);
        chk("busy_after", longint'(busy), 0, 0);
    endtask

    task automatic run_frame(input larr_t ir, input larr_t ii, input bit has_tab,
                             input larr_t tr, input larr_t ti, input int tol,
                             input int stall_n, input int stall_len, input bit junk);
        push_exp(ir, ii, has_tab, tr, ti, tol);
        send_frame(ir, ii);
        wait_out(junk);
        recv_frame(stall_n, stall_len);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        larr_t ir, ii, tr, ti;
        int    tone_re [8] = '{1024, 724, 0, -724, -1024, -724, 0, 724};
        int    tone_im [8] = '{0, 724, 1024, 724, 0, -724, -1024, -724};
        int    cnt;

        total = 0;
        bad   = 0;
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_re    = '0;
        bus.s_im    = '0;
        bus.m_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", longint'(bus.s_ready), 1, 0);
        chk("rst_m_valid", longint'(bus.m_valid), 0, 0);
        chk("rst_m_last", longint'(bus.m_last), 0, 0);
        chk("rst_busy", longint'(busy), 0, 0);
        chk("rst_m_re", longint'(bus.m_re), 0, 0);
        chk("rst_m_im", longint'(bus.m_im), 0, 0);
        rst_n = 1'b1;

        // Known transforms: impulse, DC, single tone at bin 1
        for (int v = 0; v < 3; v++) vt[v] = '0;
        vt[0].in_re[0] = 16'd8192;
        for (int i = 0; i < 8; i++) vt[0].ex_re[i] = 16'd1024;
        vt[0].tol = 4'd0;
        for (int i = 0; i < 8; i++) vt[1].in_re[i] = 16'd8192;
        vt[1].ex_re[0] = 16'd8192;
        vt[1].tol = 4'd1;
        vt[2].in_re[1] = 16'd8192;
        for (int i = 0; i < 8; i++) begin
            vt[2].ex_re[i] = 16'(tone_re[i]);
            vt[2].ex_im[i] = 16'(tone_im[i]);
        end
        vt[2].tol = 4'd1;

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 8; i++) begin
                ir[i] = longint'($signed(vt[v].in_re[i]));
                ii[i] = longint'($signed(vt[v].in_im[i]));
                tr[i] = longint'($signed(vt[v].ex_re[i]));
                ti[i] = longint'($signed(vt[v].ex_im[i]));
            end
            // Tone frame also stalls at n = 3 for 5 cycles and offers junk during COMPUTE
            if (v == 2) run_frame(ir, ii, 1'b1, tr, ti, int'(vt[v].tol), 3, 5, 1'b1);
            else        run_frame(ir, ii, 1'b1, tr, ti, int'(vt[v].tol), -1, 0, 1'b0);
        end

        // Saturation: full-scale alternating bins
        for (int i = 0; i < 8; i++) begin
            ir[i] = (i % 2 == 0) ? -32768 : 32767;
            ii[i] = (i % 2 == 0) ? 32767 : -32768;
            tr[i] = 0;
            ti[i] = 0;
        end
        run_frame(ir, ii, 1'b0, tr, ti, 0, -1, 0, 1'b0);

        // Random frames against the model
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                ir[i] = longint'($urandom_range(0, 65535)) - 32768;
                ii[i] = longint'($urandom_range(0, 65535)) - 32768;
            end
            run_frame(ir, ii, 1'b0, tr, ti, 0, (f == 0) ? 7 : 0, 2, 1'b0);
        end

        // Reset in the middle of COMPUTE aborts the frame
        for (int i = 0; i < 8; i++) begin
            ir[i] = longint'($urandom_range(0, 65535)) - 32768;
            ii[i] = 0;
        end
        send_frame(ir, ii);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_s_ready", longint'(bus.s_ready), 1, 0);
        chk("abort_m_valid", longint'(bus.m_valid), 0, 0);
        chk("abort_busy", longint'(busy), 0, 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.m_valid) cnt++;
        end
        chk("abort_no_output", cnt, 0, 0);

        for (int i = 0; i < 8; i++) begin
            ir[i] = longint'($urandom_range(0, 65535)) - 32768;
            ii[i] = longint'($urandom_range(0, 65535)) - 32768;
        end
        run_frame(ir, ii, 1'b0, tr, ti, 0, -1, 0, 1'b0);

        chk("sb_drained", sbq.size(), 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
